pc_redirect_ctrl: RTL and testbench
===================================

PC_REDIRECT_CTRL -- requirements
Module: pc_redirect_ctrl

Interface
REQ-001 SHALL have parameter XLEN, default 64: PC/target width.
REQ-002 SHALL have parameter RESET_PC, default 0: PC value loaded on reset.
REQ-003 SHALL have parameter FLUSH_CYCLES, default 2, legal range 1..15: bubble cycles after each applied redirect.
REQ-004 SHALL have ports:
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low reset.
- stall  in  1  hazard stall; PC holds while high.
- switch_branch  in  1  branch-taken request from the branch control stage.
- Flush  in  1  pipeline-flush indication from the branch control stage; expected equal to switch_branch.
- branch_target  in  XLEN  branch destination address.
- pc_out  out  XLEN  current fetch PC.
- pc_valid  out  1  pc_out holds a live fetch.
- if_id_flush  out  1  kill the IF/ID register contents.
- id_ex_flush  out  1  kill the ID/EX register contents.
- redirect_cnt  out  16  applied redirects, saturating.
- misalign_err  out  1  sticky: a target had bits [1:0] nonzero.
- ctrl_err  out  1  sticky: Flush differed from switch_branch.

Function
REQ-005 SHALL implement states RUN, HOLD and FLUSHING; all outputs SHALL be registered.
REQ-006 In RUN with switch_branch=0, the block SHALL hold pc_out when stall=1 and SHALL load pc_out+4 when stall=0; the addition wraps modulo 2^XLEN.
REQ-007 In RUN with switch_branch=1 and stall=0, the block SHALL apply a redirect on that edge:
- pc_out <= {branch_target[XLEN-1:2],2'b00}
- next state FLUSHING; flush counter <= FLUSH_CYCLES.
REQ-008 In RUN with switch_branch=1 and stall=1, the block SHALL:
- capture the aligned target into a pending register;
- hold pc_out;
- move to HOLD.
REQ-009 In HOLD, pc_out SHALL hold while stall=1; on the first edge with stall=0, the block SHALL apply the pending target per REQ-007.
REQ-010 In HOLD, switch_branch SHALL be ignored, so the first captured target wins.
REQ-011 While the state is FLUSHING, if_id_flush, id_ex_flush and pc_valid SHALL behave as follows:
- if_id_flush=1 and id_ex_flush=1;
- pc_valid=0.
REQ-012 In FLUSHING, pc_out SHALL advance by 4 on each edge with stall=0, and the flush counter SHALL decrement on the same edges.
REQ-013 The block SHALL leave FLUSHING for RUN on the edge where the flush counter decrements from 1.
REQ-014 In FLUSHING, switch_branch SHALL be ignored, because it belongs to squashed instructions.
REQ-015 In RUN and HOLD, if_id_flush and id_ex_flush SHALL be 0; pc_valid SHALL be 1 in RUN and 0 in HOLD.
REQ-016 The block SHALL increment redirect_cnt by 1 on each applied redirect and SHALL saturate it at 16'hFFFF.
REQ-017 The block SHALL set misalign_err on any edge where a target is captured or applied and branch_target[1:0] != 0.
REQ-018 The block SHALL set ctrl_err on any edge in RUN where Flush != switch_branch; Flush SHALL have no other effect.
REQ-019 misalign_err and ctrl_err SHALL be cleared only by reset.
REQ-020 When switch_branch and stall rise on the same edge, HOLD (REQ-008) SHALL take priority over the PC increment.

Reset
REQ-021 While reset=0, the block SHALL asynchronously force the following, and SHALL clear the pending target and flush counter:
- pc_out=RESET_PC, state RUN;
- pc_valid=0, if_id_flush=0, id_ex_flush=0;
- redirect_cnt=0, misalign_err=0, ctrl_err=0.
REQ-022 On the first edge after reset release, pc_valid SHALL rise to 1 and pc_out SHALL stay at RESET_PC; normal increments SHALL start on the following edge.
REQ-023 Reset asserted during HOLD or FLUSHING SHALL discard the pending redirect and the flush count immediately.

Verification
REQ-024 A bench SHALL cover these directed scenarios:
- Reset release, stall=0, no branch for 4 edges -> pc_out = 0,0,4,8,12; pc_valid=1 from the first edge.
- At pc_out=0x10, switch_branch=Flush=1, target 0x100, stall=0 -> pc_out=0x100; flushes=1 and pc_valid=0 for 2 cycles; then pc_out=0x108 in RUN; redirect_cnt=1.
- Branch to 0x200 with stall=1 held 3 cycles -> pc_out frozen, state HOLD; a second branch to 0x300 during HOLD is ignored; 0x200 is applied on the first stall=0 edge.
- Target 0x102 -> pc_out=0x100 and misalign_err=1; switch_branch=1 with Flush=0 in RUN -> ctrl_err=1; both remain set until reset.
- pc_out=0xFFFF_FFFF_FFFF_FFFC with no branch -> pc_out=0 on the next unstalled edge.
- Reset pulsed low mid-FLUSHING -> all outputs return to reset values asynchronously; redirect_cnt=0.

Source files
------------

// File: rtl/pc_redirect_ctrl.sv
// Fetch-PC sequencer: sequential increment, branch redirect with stall-aware
// deferral (HOLD), and a fixed-length pipeline flush window after each redirect.
module pc_redirect_ctrl #(
  parameter int XLEN         = 64,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            switch_branch,
  input  logic            Flush,
  input  logic [XLEN-1:0] branch_target,
  output logic [XLEN-1:0] pc_out,
  output logic            pc_valid,
  output logic            if_id_flush,
  output logic            id_ex_flush,
  output logic [15:0]     redirect_cnt,
  output logic            misalign_err,
  output logic            ctrl_err
);

  typedef enum logic [1:0] {RUN, HOLD, FLUSHING} state_t;

  state_t          state_reg, state_next;
  logic [XLEN-1:0] pc_reg, pc_next;
  logic [XLEN-1:0] pending_reg, pending_next;
  logic [3:0]      flush_cnt_reg, flush_cnt_next;
  logic [15:0]     cnt_reg, cnt_next;
  logic            started_reg;
  logic            pc_valid_reg, flush_reg;
  logic            mis_reg, mis_next;
  logic            cerr_reg, cerr_next;
  logic            redirect;
  logic [XLEN-1:0] redirect_pc;
  logic [XLEN-1:0] aligned_target;

  assign aligned_target = {branch_target[XLEN-1:2], 2'b00};

  always_comb begin
    state_next     = state_reg;
    pc_next        = pc_reg;
    pending_next   = pending_reg;
    flush_cnt_next = flush_cnt_reg;
    cnt_next       = cnt_reg;
    mis_next       = mis_reg;
    cerr_next      = cerr_reg;
    redirect       = 1'b0;
    redirect_pc    = pending_reg;

    case (state_reg)
      RUN: begin
        if (Flush != switch_branch) cerr_next = 1'b1;
        // The first edge after reset only raises pc_valid; fetch begins after it.
        if (started_reg) begin
          if (switch_branch) begin
            if (|branch_target[1:0]) mis_next = 1'b1;
            if (stall) begin
              pending_next = aligned_target;
              state_next   = HOLD;
            end else begin
              redirect    = 1'b1;
              redirect_pc = aligned_target;
            end
          end else if (!stall) begin
            pc_next = pc_reg + XLEN'(4);
          end
        end
      end
      HOLD: begin
        if (!stall) redirect = 1'b1;
      end
      FLUSHING: begin
        if (!stall) begin
          pc_next        = pc_reg + XLEN'(4);
          flush_cnt_next = flush_cnt_reg - 4'd1;
          if (flush_cnt_reg == 4'd1) state_next = RUN;
        end
      end
      default: state_next = RUN;
    endcase

    if (redirect) begin
      pc_next        = redirect_pc;
      state_next     = FLUSHING;
      flush_cnt_next = 4'(FLUSH_CYCLES);
      if (cnt_reg != 16'hFFFF) cnt_next = cnt_reg + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= RUN;
      pc_reg        <= RESET_PC;
      pending_reg   <= '0;
      flush_cnt_reg <= '0;
      cnt_reg       <= '0;
      started_reg   <= 1'b0;
      pc_valid_reg  <= 1'b0;
      flush_reg     <= 1'b0;
      mis_reg       <= 1'b0;
      cerr_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      pc_reg        <= pc_next;
      pending_reg   <= pending_next;
      flush_cnt_reg <= flush_cnt_next;
      cnt_reg       <= cnt_next;
      started_reg   <= 1'b1;
      // Status flags are registered from the next state so they track state_reg.
      pc_valid_reg  <= (state_next == RUN);
      flush_reg     <= (state_next == FLUSHING);
      mis_reg       <= mis_next;
      cerr_reg      <= cerr_next;
    end
  end

  assign pc_out       = pc_reg;
  assign pc_valid     = pc_valid_reg;
  assign if_id_flush  = flush_reg;
  assign id_ex_flush  = flush_reg;
  assign redirect_cnt = cnt_reg;
  assign misalign_err = mis_reg;
  assign ctrl_err     = cerr_reg;

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Self-checking bench for pc_redirect_ctrl: directed scenarios plus randomized
// traffic compared against a cycle-level behavioural model.
module tb_pc_redirect_ctrl;

  localparam int XLEN = 64;
  localparam int FC   = 2;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            stall = 1'b0;
  logic            switch_branch = 1'b0;
  logic            Flush = 1'b0;
  logic [XLEN-1:0] branch_target = '0;
  logic [XLEN-1:0] pc_out;
  logic            pc_valid, if_id_flush, id_ex_flush, misalign_err, ctrl_err;
  logic [15:0]     redirect_cnt;

  int vectors = 0;
  int miscompares = 0;

  pc_redirect_ctrl #(.XLEN(XLEN), .RESET_PC('0), .FLUSH_CYCLES(FC)) dut (
    .clk(clk), .reset(reset), .stall(stall), .switch_branch(switch_branch),
    .Flush(Flush), .branch_target(branch_target), .pc_out(pc_out),
    .pc_valid(pc_valid), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .redirect_cnt(redirect_cnt), .misalign_err(misalign_err), .ctrl_err(ctrl_err)
  );

  always #5 clk = ~clk;

  // Behavioural model: a fetch PC, an optional deferred target, a count of
  // bubbles still owed, and sticky flags.
  logic [XLEN-1:0] m_pc, m_target;
  int  m_bubbles, m_cnt;
  bit  m_live, m_wait, m_mis, m_cerr;

  function automatic void model_reset();
    m_pc = '0; m_target = '0; m_bubbles = 0; m_cnt = 0;
    m_live = 0; m_wait = 0; m_mis = 0; m_cerr = 0;
  endfunction

  function automatic void model_redirect(logic [XLEN-1:0] t);
    m_pc = t; m_bubbles = FC; m_wait = 0;
    if (m_cnt < 65535) m_cnt++;
  endfunction

  function automatic void model_edge();
    bit running = !m_wait && (m_bubbles == 0);
    logic [XLEN-1:0] t = branch_target;
    t[1:0] = 2'b00;
    if (running && (Flush != switch_branch)) m_cerr = 1;
    if (!m_live) m_live = 1;
    else if (m_bubbles > 0) begin
      if (!stall) begin m_pc = m_pc + 4; m_bubbles--; end
    end else if (m_wait) begin
      if (!stall) model_redirect(m_target);
    end else if (switch_branch) begin
      if (branch_target[1:0] != 2'b00) m_mis = 1;
      if (stall) begin m_wait = 1; m_target = t; end
      else model_redirect(t);
    end else if (!stall) m_pc = m_pc + 4;
  endfunction

  function automatic logic [84:0] exp_vec();
    bit valid = m_live && !m_wait && (m_bubbles == 0);
    bit fl = (m_bubbles > 0);
    return {m_pc, valid, fl, fl, 16'(m_cnt), m_mis, m_cerr};
  endfunction

  function automatic logic [84:0] dut_vec();
    return {pc_out, pc_valid, if_id_flush, id_ex_flush, redirect_cnt, misalign_err, ctrl_err};
  endfunction

  task automatic tick();
    @(posedge clk);
    if (reset) model_edge(); else model_reset();
    #1;
  endtask

  task automatic drive(bit st, bit sb, bit fl, logic [XLEN-1:0] tgt);
    stall = st; switch_branch = sb; Flush = fl; branch_target = tgt;
  endtask

  task automatic test_reset();
    logic [XLEN-1:0] exp_pc [5];
    exp_pc = '{64'h0, 64'h0, 64'h4, 64'h8, 64'hC};
    drive(0, 0, 0, '0);
    reset = 1'b0; model_reset();
    #12;
    vectors++;
    if (dut_vec() !== 85'h0) begin
      miscompares++; $display("FAIL reset_state: got %h expected %h", dut_vec(), 85'h0);
    end
    @(posedge clk); #1 reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) tick();
      vectors++;
      if (pc_out !== exp_pc[i] || pc_valid !== (i > 0) || dut_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL reset_release[%0d]: got pc=%h valid=%b expected pc=%h valid=%b", i, pc_out, pc_valid, exp_pc[i], i > 0);
      end
      $display("reset_release edge %0d pc=%h valid=%b", i, pc_out, pc_valid);
    end
  endtask

  task automatic test_redirect();
    logic [XLEN-1:0] exp_pc [4];
    exp_pc = '{64'h100, 64'h104, 64'h108, 64'h10C};
    tick();
    vectors++;
    if (pc_out !== 64'h10) begin
      miscompares++; $display("FAIL pre_redirect_pc: got %h expected %h", pc_out, 64'h10);
    end
    drive(0, 1, 1, 64'h100);
    for (int i = 0; i < 4; i++) begin
      tick();
      drive(0, 0, 0, '0);
      vectors++;
      if (pc_out !== exp_pc[i] || if_id_flush !== (i < 2) || id_ex_flush !== (i < 2) ||
          pc_valid !== (i >= 2) || redirect_cnt !== 16'd1 || dut_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL redirect[%0d]: got pc=%h fl=%b val=%b cnt=%0d expected pc=%h fl=%b", i, pc_out, if_id_flush, pc_valid, redirect_cnt, exp_pc[i], i < 2);
      end
      $display("redirect edge %0d pc=%h flush=%b valid=%b", i, pc_out, if_id_flush, pc_valid);
    end
  endtask

  task automatic test_hold();
    logic [XLEN-1:0] frozen = pc_out;
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 1, (i == 0) ? 64'h200 : 64'h300);
      tick();
      vectors++;
      if (pc_out !== frozen || pc_valid !== 1'b0 || if_id_flush !== 1'b0 || dut_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL hold[%0d]: got pc=%h valid=%b flush=%b expected pc=%h valid=0 flush=0", i, pc_out, pc_valid, if_id_flush, frozen);
      end
      $display("hold edge %0d pc=%h", i, pc_out);
    end
    drive(0, 1, 1, 64'h300);
    tick();
    drive(0, 0, 0, '0);
    vectors++;
    if (pc_out !== 64'h200 || if_id_flush !== 1'b1 || redirect_cnt !== 16'd2 || dut_vec() !== exp_vec()) begin
      miscompares++;
      $display("FAIL hold_apply: got pc=%h flush=%b cnt=%0d expected pc=%h flush=1 cnt=2", pc_out, if_id_flush, redirect_cnt, 64'h200);
    end
    tick(); tick();
    vectors++;
    if (pc_out !== 64'h208 || pc_valid !== 1'b1 || dut_vec() !== exp_vec()) begin
      miscompares++; $display("FAIL hold_drain: got pc=%h valid=%b expected pc=%h valid=1", pc_out, pc_valid, 64'h208);
    end
    $display("hold applied, pc=%h", pc_out);
  endtask

  task automatic test_errors();
    drive(0, 1, 1, 64'h102);
    tick();
    drive(0, 0, 0, '0);
    vectors++;
    if (pc_out !== 64'h100 || misalign_err !== 1'b1 || ctrl_err !== 1'b0 || dut_vec() !== exp_vec()) begin
      miscompares++;
      $display("FAIL misalign: got pc=%h mis=%b cerr=%b expected pc=%h mis=1 cerr=0", pc_out, misalign_err, ctrl_err, 64'h100);
    end
    tick(); tick();
    drive(0, 1, 0, 64'h400);
    tick();
    drive(0, 0, 0, '0);
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (ctrl_err !== 1'b1 || misalign_err !== 1'b1 || dut_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL sticky_err[%0d]: got mis=%b cerr=%b expected mis=1 cerr=1", i, misalign_err, ctrl_err);
      end
      $display("errors edge %0d pc=%h mis=%b cerr=%b", i, pc_out, misalign_err, ctrl_err);
      tick();
    end
  endtask

  task automatic test_wrap();
    logic [XLEN-1:0] top = 64'hFFFF_FFFF_FFFF_FFFC;
    drive(0, 1, 1, top);
    tick();
    drive(1, 0, 0, '0);
    tick();
    vectors++;
    if (pc_out !== top || dut_vec() !== exp_vec()) begin
      miscompares++; $display("FAIL wrap_hold: got %h expected %h", pc_out, top);
    end
    drive(0, 0, 0, '0);
    tick();
    vectors++;
    if (pc_out !== 64'h0 || dut_vec() !== exp_vec()) begin
      miscompares++; $display("FAIL wrap: got %h expected %h", pc_out, 64'h0);
    end
    $display("wrap pc=%h", pc_out);
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      bit sb = ($urandom_range(0, 3) == 0);
      bit fl = ($urandom_range(0, 19) == 0) ? !sb : sb;
      logic [XLEN-1:0] tgt = {$urandom, $urandom};
      if ($urandom_range(0, 3) != 0) tgt[1:0] = 2'b00;
      drive($urandom_range(0, 2) == 0, sb, fl, tgt);
      tick();
      vectors++;
      if (dut_vec() !== exp_vec()) begin
        miscompares++; $display("FAIL random[%0d]: got %h expected %h", i, dut_vec(), exp_vec());
      end
      $display("random %0d pc=%h valid=%b flush=%b cnt=%0d", i, pc_out, pc_valid, if_id_flush, redirect_cnt);
    end
  endtask

  task automatic test_async_reset();
    drive(0, 1, 1, 64'h800);
    tick();
    drive(1, 0, 0, '0);
    tick();
    vectors++;
    if (if_id_flush !== 1'b1 || dut_vec() !== exp_vec()) begin
      miscompares++; $display("FAIL pre_async_flush: got %h expected %h", dut_vec(), exp_vec());
    end
    #3 reset = 1'b0;
    model_reset();
    #1;
    vectors++;
    if (dut_vec() !== 85'h0) begin
      miscompares++; $display("FAIL async_reset: got %h expected %h", dut_vec(), 85'h0);
    end
    $display("async reset pc=%h cnt=%0d", pc_out, redirect_cnt);
    drive(0, 0, 0, '0);
    tick();
    #2 reset = 1'b1;
    tick();
    vectors++;
    if (pc_out !== 64'h0 || pc_valid !== 1'b1 || if_id_flush !== 1'b0 || dut_vec() !== exp_vec()) begin
      miscompares++; $display("FAIL post_reset: got pc=%h valid=%b expected pc=0 valid=1", pc_out, pc_valid);
    end
    tick();
    vectors++;
    if (pc_out !== 64'h4 || dut_vec() !== exp_vec()) begin
      miscompares++; $display("FAIL post_reset_inc: got %h expected %h", pc_out, 64'h4);
    end
  endtask

  initial begin
    test_reset();
    test_redirect();
    test_hold();
    test_errors();
    test_wrap();
    test_random();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
